serial_addsub: RTL

//  Parametrised bit-serial adder/subtractor: successor to the single-bit full-adder cell.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and mode values.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ cin_i;
   assign co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one full-adder cell with a registered carry.
// state    | meaning
// IDLE     | waiting for start; outputs hold the last result
// SHIFT    | one operand bit per clock through the full adder
// DONE     | result valid, done pulse for one cycle
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             overflow_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cin_msb_q, cin_msb_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_s, fa_co;

   fa_cell u_fa (
      .a_i   (a_q[0]),
      .b_i   (b_q[0]),
      .cin_i (carry_q),
      .s_o   (fa_s),
      .co_o  (fa_co)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               // Subtract is a + ~b + 1: invert b here and seed the carry with the mode bit.
               a_d     = a_i;
               b_d     = (mode_i == SUB) ? ~b_i : b_i;
               carry_d = mode_i;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_MSB) begin
               cin_msb_d = fa_co;
            end
            if (cnt_q == CNT_LAST) begin
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               ovf_d   = cin_msb_q ^ fa_co;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);
   assign sum_o      = sum_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

endmodule
